// File: rtl/eth_phy_manager.sv
// RGMII PHY bring-up and supervision: drives the PHY hardware reset, then polls BMSR (reg 1)
// over clause-22 MDIO and publishes link state, the raw status word and a no-PHY fault flag.
module eth_phy_manager #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter int unsigned RST_CYCLES  = 1000000,
    parameter int unsigned WAKE_CYCLES = 5000000,
    parameter int unsigned MDC_DIV     = 50,
    parameter int unsigned POLL_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        phy_rst_n,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in,
    output logic        link_up,
    output logic [15:0] bmsr,
    output logic        bmsr_valid,
    output logic        phy_fault
);

    localparam int unsigned MAX_RW   = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
    localparam int unsigned MAX_WAIT = (MAX_RW > POLL_CYCLES) ? MAX_RW : POLL_CYCLES;
    localparam int unsigned WW       = $clog2(MAX_WAIT + 1);
    localparam int unsigned CELL     = 2 * MDC_DIV;
    localparam int unsigned CW       = $clog2(CELL);

    localparam logic [WW-1:0] RST_LAST  = WW'(RST_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
    localparam logic [WW-1:0] POLL_LAST = WW'(POLL_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_ONE  = WW'(1);
    localparam logic [CW-1:0] CELL_LAST = CW'(CELL - 1);
    localparam logic [CW-1:0] MDC_HI    = CW'(MDC_DIV - 1);
    localparam logic [CW-1:0] CELL_ONE  = CW'(1);

    // Driven part of a read frame, frame bit b lives at HDR[45-b]
    localparam logic [45:0] HDR = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, 5'd1};

    typedef enum logic [2:0] {
        S_RESET,
        S_WAKE,
        S_READ1,
        S_READ2,
        S_IDLE
    } state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait;
    logic [CW-1:0] r_cell;
    logic [5:0]    r_bit;
    logic [15:0]   r_shift;
    logic          r_sync1;
    logic          r_sync2;
    logic          r_phy_rst_n;
    logic          r_mdc;
    logic          r_mdio_out;
    logic          r_mdio_oe;
    logic          r_link_up;
    logic [15:0]   r_bmsr;
    logic          r_bmsr_valid;
    logic          r_phy_fault;

    logic [5:0]    w_bit_next;
    logic [5:0]    w_idx;
    logic          w_oe_next;
    logic          w_out_next;
    logic [15:0]   w_data;

    always_comb begin
        w_bit_next = r_bit + 6'd1;
        w_idx      = 6'd45 - w_bit_next;
        w_oe_next  = (w_bit_next < 6'd46);
        w_out_next = w_oe_next ? HDR[w_idx] : 1'b1;
        w_data     = {r_shift[14:0], r_sync2};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_RESET;
            r_wait       <= '0;
            r_cell       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_phy_rst_n  <= 1'b0;
            r_mdc        <= 1'b0;
            r_mdio_out   <= 1'b1;
            r_mdio_oe    <= 1'b0;
            r_link_up    <= 1'b0;
            r_bmsr       <= '0;
            r_bmsr_valid <= 1'b0;
            r_phy_fault  <= 1'b0;
        end else begin
            r_sync1      <= mdio_in;
            r_sync2      <= r_sync1;
            r_bmsr_valid <= 1'b0;
            case (r_state)
                S_RESET: begin
                    if (r_wait == RST_LAST) begin
                        r_wait      <= '0;
                        r_phy_rst_n <= 1'b1;
                        r_state     <= S_WAKE;
                    end else begin
                        r_wait <= r_wait + WAIT_ONE;
                    end
                end
                S_WAKE, S_IDLE: begin
                    if (r_wait == ((r_state == S_WAKE) ? WAKE_LAST : POLL_LAST)) begin
                        r_wait     <= '0;
                        r_cell     <= '0;
                        r_bit      <= '0;
                        r_mdc      <= 1'b0;
                        r_mdio_oe  <= 1'b1;
                        r_mdio_out <= HDR[45];
                        r_state    <= S_READ1;
                    end else begin
                        r_wait <= r_wait + WAIT_ONE;
                    end
                end
                S_READ1, S_READ2: begin
                    if (r_cell == MDC_HI) begin
                        r_mdc <= 1'b1;
                    end
                    // Last cycle of a cell: sample data, then set up the next cell's pin values
                    if (r_cell == CELL_LAST) begin
                        r_cell <= '0;
                        r_mdc  <= 1'b0;
                        if (r_bit >= 6'd48) begin
                            r_shift <= w_data;
                        end
                        if (r_bit == 6'd63) begin
                            r_bit <= '0;
                            if (r_state == S_READ1) begin
                                r_mdio_oe  <= 1'b1;
                                r_mdio_out <= HDR[45];
                                r_state    <= S_READ2;
                            end else begin
                                r_mdio_oe    <= 1'b0;
                                r_mdio_out   <= 1'b1;
                                r_bmsr       <= w_data;
                                r_phy_fault  <= (w_data == 16'hFFFF);
                                r_link_up    <= w_data[2] & (w_data != 16'hFFFF);
                                r_bmsr_valid <= 1'b1;
                                r_state      <= S_IDLE;
                            end
                        end else begin
                            r_bit      <= w_bit_next;
                            r_mdio_oe  <= w_oe_next;
                            r_mdio_out <= w_out_next;
                        end
                    end else begin
                        r_cell <= r_cell + CELL_ONE;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                end
            endcase
        end
    end

    assign phy_rst_n  = r_phy_rst_n;
    assign mdc        = r_mdc;
    assign mdio_out   = r_mdio_out;
    assign mdio_oe    = r_mdio_oe;
    assign link_up    = r_link_up;
    assign bmsr       = r_bmsr;
    assign bmsr_valid = r_bmsr_valid;
    assign phy_fault  = r_phy_fault;

endmodule
